// File: rtl/controle_exibicao.sv
// Display-content controller: keeps a saturating score and a latched note letter,
// and chooses which one the 7-segment converter shows.
module controle_exibicao #(
  parameter int CICLOS_LETRA = 1000,
  parameter int PONTOS_MAX   = 255
) (
  input  logic       clock,
  input  logic       zera_as_n,
  input  logic       zera_s,
  input  logic       acerto,
  input  logic       erro,
  input  logic       carrega_letra,
  input  logic [4:0] letra_in,
  output logic [7:0] numero,
  output logic [4:0] letra,
  output logic       select,
  output logic       zera_contador_display,
  output logic [1:0] db_estado
);

  localparam int TW = (CICLOS_LETRA > 1) ? $clog2(CICLOS_LETRA) : 1;
  localparam logic [TW-1:0] TIMER_FIM = TW'(CICLOS_LETRA - 1);
  localparam logic [7:0] NUMERO_MAX = 8'(PONTOS_MAX);

  typedef enum logic [1:0] {
    INICIAL       = 2'b00,
    MOSTRA_NUMERO = 2'b01,
    MOSTRA_LETRA  = 2'b10,
    INVALIDO      = 2'b11
  } estado_t;

  estado_t         estado, prox_estado;
  logic [TW-1:0]   timer, prox_timer;
  logic [4:0]      prox_letra;
  logic            prox_zera;
  logic [7:0]      prox_numero;

  // A reload always restarts the letter window, even on the cycle it would expire.
  always_comb begin
    prox_estado = estado;
    prox_timer  = '0;
    prox_letra  = letra;
    prox_zera   = 1'b0;
    case (estado)
      INICIAL: begin
        prox_estado = MOSTRA_NUMERO;
        prox_zera   = 1'b1;
      end
      MOSTRA_NUMERO: begin
        if (carrega_letra) begin
          prox_letra  = letra_in;
          prox_estado = MOSTRA_LETRA;
          prox_zera   = 1'b1;
        end
      end
      MOSTRA_LETRA: begin
        if (carrega_letra) begin
          prox_letra = letra_in;
          prox_zera  = 1'b1;
        end else if (timer == TIMER_FIM) begin
          prox_estado = MOSTRA_NUMERO;
          prox_zera   = 1'b1;
        end else begin
          prox_timer = timer + TW'(1);
        end
      end
      default: prox_estado = INICIAL;
    endcase
  end

  // Simultaneous hit and miss cancel out; the score never wraps.
  always_comb begin
    prox_numero = numero;
    if (acerto && !erro && (numero < NUMERO_MAX))
      prox_numero = numero + 8'd1;
    else if (erro && !acerto && (numero != 8'd0))
      prox_numero = numero - 8'd1;
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      estado                <= INICIAL;
      timer                 <= '0;
      numero                <= '0;
      letra                 <= '0;
      select                <= 1'b0;
      zera_contador_display <= 1'b0;
    end else if (zera_s) begin
      estado                <= INICIAL;
      timer                 <= '0;
      numero                <= '0;
      letra                 <= '0;
      select                <= 1'b0;
      zera_contador_display <= 1'b0;
    end else begin
      estado                <= prox_estado;
      timer                 <= prox_timer;
      numero                <= prox_numero;
      letra                 <= prox_letra;
      select                <= (prox_estado == MOSTRA_LETRA);
      zera_contador_display <= prox_zera;
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_exibicao.sv
// Bench for controle_exibicao: directed vectors, a cycle-level behavioural model
// compared on every edge, and literal spot checks that pin the model.
module tb_controle_exibicao;

  localparam int CL   = 4;
  localparam int PMAX = 10;

  logic       clock = 1'b0;
  logic       zera_as_n = 1'b0;
  logic       zera_s = 1'b0;
  logic       acerto = 1'b0;
  logic       erro = 1'b0;
  logic       carrega_letra = 1'b0;
  logic [4:0] letra_in = 5'd0;
  logic [7:0] numero;
  logic [4:0] letra;
  logic       select;
  logic       zera_contador_display;
  logic [1:0] db_estado;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 = initial, 1 = number, 2 = letter; restante = letter cycles left.
  int         m_numero = 0;
  logic [4:0] m_letra = 5'd0;
  int         m_modo = 0;
  int         m_restante = 0;
  logic       m_zera = 1'b0;

  controle_exibicao #(.CICLOS_LETRA(CL), .PONTOS_MAX(PMAX)) dut (
    .clock(clock),
    .zera_as_n(zera_as_n),
    .zera_s(zera_s),
    .acerto(acerto),
    .erro(erro),
    .carrega_letra(carrega_letra),
    .letra_in(letra_in),
    .numero(numero),
    .letra(letra),
    .select(select),
    .zera_contador_display(zera_contador_display),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic e, input logic c, input logic [4:0] l, input logic z);
    @(negedge clock);
    acerto = a;
    erro = e;
    carrega_letra = c;
    letra_in = l;
    zera_s = z;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Model update on every clock edge or reset assertion, then compare just after it.
  always @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n || zera_s) begin
      m_numero = 0;
      m_letra = 5'd0;
      m_modo = 0;
      m_restante = 0;
      m_zera = 1'b0;
    end else begin
      if (acerto && !erro) m_numero = (m_numero + 1 > PMAX) ? PMAX : m_numero + 1;
      else if (erro && !acerto) m_numero = (m_numero - 1 < 0) ? 0 : m_numero - 1;
      m_zera = 1'b0;
      if (m_modo == 0) begin
        m_modo = 1;
        m_zera = 1'b1;
      end else if (carrega_letra) begin
        m_letra = letra_in;
        m_modo = 2;
        m_restante = CL;
        m_zera = 1'b1;
      end else if (m_modo == 2) begin
        m_restante = m_restante - 1;
        if (m_restante == 0) begin
          m_modo = 1;
          m_zera = 1'b1;
        end
      end
    end
    #1;
    checkOutput("model_numero", 32'(numero), 32'(m_numero));
    checkOutput("model_letra", 32'(letra), 32'(m_letra));
    checkOutput("model_select", 32'(select), 32'(m_modo == 2));
    checkOutput("model_zera", 32'(zera_contador_display), 32'(m_zera));
    checkOutput("model_estado", 32'(db_estado), 32'(m_modo));
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #8;
    checkOutput("reset_numero", 32'(numero), 32'd0);
    checkOutput("reset_select", 32'(select), 32'd0);
    checkOutput("reset_estado", 32'(db_estado), 32'd0);
    #4 zera_as_n = 1'b1;
    #1 checkOutput("release_estado", 32'(db_estado), 32'd0);
    @(negedge clock);
    checkOutput("entry_estado", 32'(db_estado), 32'd1);
    checkOutput("entry_zera", 32'(zera_contador_display), 32'd1);
    idle(1);
    checkOutput("entry_zera_off", 32'(zera_contador_display), 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    idle(1);
    checkOutput("score_5", 32'(numero), 32'd5);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    idle(1);
    checkOutput("score_3", 32'(numero), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    idle(1);
    checkOutput("score_both", 32'(numero), 32'd3);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    idle(1);
    checkOutput("score_floor", 32'(numero), 32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    idle(1);
    checkOutput("score_ceiling", 32'(numero), 32'd10);

    applyStimulus(1'b0, 1'b0, 1'b1, 5'h0A, 1'b0);
    idle(1);
    checkOutput("load_letra", 32'(letra), 32'h0A);
    checkOutput("load_select", 32'(select), 32'd1);
    checkOutput("load_zera", 32'(zera_contador_display), 32'd1);
    idle(3);
    checkOutput("letter_last_cycle", 32'(select), 32'd1);
    idle(1);
    checkOutput("expire_select", 32'(select), 32'd0);
    checkOutput("expire_zera", 32'(zera_contador_display), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, 5'h0A, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h03, 1'b0);
    idle(1);
    checkOutput("reload_letra", 32'(letra), 32'h03);
    checkOutput("reload_select", 32'(select), 32'd1);
    checkOutput("reload_zera", 32'(zera_contador_display), 32'd1);
    idle(3);
    checkOutput("reload_last_cycle", 32'(select), 32'd1);
    idle(1);
    checkOutput("reload_expire", 32'(select), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b1, 5'h0A, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(1);
    checkOutput("clear_numero", 32'(numero), 32'd0);
    checkOutput("clear_letra", 32'(letra), 32'd0);
    checkOutput("clear_select", 32'(select), 32'd0);
    checkOutput("clear_estado", 32'(db_estado), 32'd0);
    idle(1);
    checkOutput("clear_reentry", 32'(db_estado), 32'd1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h0B, 1'b0);
    idle(2);
    checkOutput("pre_async_select", 32'(select), 32'd1);
    #2 zera_as_n = 1'b0;
    #1;
    checkOutput("async_numero", 32'(numero), 32'd0);
    checkOutput("async_letra", 32'(letra), 32'd0);
    checkOutput("async_select", 32'(select), 32'd0);
    checkOutput("async_estado", 32'(db_estado), 32'd0);
    @(posedge clock);
    #2 zera_as_n = 1'b1;
    idle(2);
    checkOutput("async_reentry", 32'(db_estado), 32'd1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_exibicao.md
Name: controle_exibicao

Overview:
- Display-content controller sitting directly upstream of the 7-segment converter.
- Keeps an 8-bit saturating score, updated by hit/miss pulses from the game FSM, and a latched note letter.
- Decides when the display shows the number and when it shows the letter, and drives the converter's numero, letra, select and zera_contador_display inputs.
- All outputs are registered.

Parameters:
- CICLOS_LETRA, 1000, number of clock cycles a loaded letter stays on the display (>=2).
- PONTOS_MAX, 255, saturation ceiling of the score (1..255).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- zera_as_n  input  1  asynchronous active-low reset.
- zera_s  input  1  synchronous clear, active-high.
- acerto  input  1  one-cycle pulse; score +1.
- erro  input  1  one-cycle pulse; score -1.
- carrega_letra  input  1  one-cycle pulse; latch letra_in and show it.
- letra_in  input  5  letter code to display.
- numero  output  8  current score, to converter numero.
- letra  output  5  latched letter, to converter letra.
- select  output  1  0 = show number, 1 = show letter.
- zera_contador_display  output  1  one-cycle pulse restarting the converter's digit scan.
- db_estado  output  2  FSM state, for debug.

Behaviour:
- Reset (zera_as_n=0, asynchronous):
  - numero=0, letra=0, select=0, zera_contador_display=0, timer=0, state=INICIAL.
- FSM encoding: INICIAL=00, MOSTRA_NUMERO=01, MOSTRA_LETRA=10; 11 is unused and recovers to INICIAL on the next edge.
- INICIAL:
  - select=0.
  - Unconditionally goes to MOSTRA_NUMERO on the next edge, with zera_contador_display=1 for that one cycle.
- MOSTRA_NUMERO:
  - select=0.
  - On carrega_letra=1 at an edge: letra<=letra_in, timer<=0, state goes to MOSTRA_LETRA, select=1 and zera_contador_display=1, all visible the cycle after that edge.
- MOSTRA_LETRA:
  - select=1; timer increments every cycle.
  - When timer==CICLOS_LETRA-1: state goes to MOSTRA_NUMERO, select=0, zera_contador_display=1 (one cycle).
  - The letter is therefore visible for exactly CICLOS_LETRA cycles.
  - carrega_letra=1 while in MOSTRA_LETRA (including on the expiry cycle): relatch letra, timer<=0, stay in MOSTRA_LETRA, pulse zera_contador_display. Carrega_letra wins over expiry.
- zera_contador_display:
  - High for exactly one cycle, in the same cycle select takes its new value, or when the letter is reloaded.
  - Low otherwise.
- Timer width is $clog2(CICLOS_LETRA); it holds at 0 outside MOSTRA_LETRA.
- Score (all states except INICIAL entry; updated one cycle after the pulse edge):
  - acerto only: numero<=min(numero+1, PONTOS_MAX).
  - erro only: numero<=max(numero-1, 0); never wraps.
  - acerto and erro together: no change.
  - Held at PONTOS_MAX or 0 on saturation; no wrap-around ever.
- zera_s=1 at an edge:
  - numero=0, letra=0, timer=0, state=INICIAL, select=0, zera_contador_display=0.
  - Overrides acerto, erro and carrega_letra in the same cycle.
- Asynchronous reset mid-letter: display returns to number 0 immediately; the letter display is abandoned.
- db_estado mirrors the state register.

Test Plan:
- Release reset, idle 3 cycles -> db_estado 00 then 01; zera_contador_display=1 for exactly one cycle on entry to 01; select=0; numero=0.
- 5 acerto pulses, then 2 erro pulses -> numero 5 then 3; acerto+erro in the same cycle -> numero stays 3.
- From numero=0, erro pulse -> numero stays 0. With PONTOS_MAX=10, 12 acerto pulses -> numero saturates at 10.
- CICLOS_LETRA=4, carrega_letra with letra_in=5'h0A:
  - letra=0A, select=1 and a zera pulse on the next cycle.
  - select=1 for exactly 4 cycles, then select=0 with a second zera pulse.
- During letter display, a second carrega_letra with letra_in=5'h03 on the expiry cycle -> letra=03, timer restarts, select stays 1 for 4 more cycles, one zera pulse at the reload.
- Mid-letter, assert zera_s together with acerto -> next cycle numero=0, letra=0, select=0, db_estado=00. Repeat using an asynchronous zera_as_n low pulse -> outputs clear without waiting for a clock edge.
